// File: rtl/router_pkg.sv
// ============================================================================
// Module      : router_pkg
// Description : Shared types and constants for the router ingress block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package router_pkg;

  localparam int         NUM_PORTS    = 3;
  localparam int         LEN_W        = 6;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_EMPTY  = 3'd1,
    ST_LOAD_HDR    = 3'd2,
    ST_LOAD_DATA   = 3'd3,
    ST_LOAD_PARITY = 3'd4,
    ST_DROP        = 3'd5
  } state_t;

  // Header carries the payload length in its upper six bits.
  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_ingress.sv
// ============================================================================
// Module      : router_ingress
// Description : Packet ingress FSM steering header/payload/parity bytes to one
//               of three destination FIFOs, with parity checking and drop.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module router_ingress
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [7:0]           data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic [7:0]           dout,
  output logic                 busy,
  output logic                 err
);

  state_t           r_state;
  logic [7:0]       r_hdr;
  logic [7:0]       r_parity;
  logic [LEN_W-1:0] r_remaining;
  logic             r_err;

  logic [1:0]       w_in_addr;
  logic [1:0]       w_addr;
  logic [3:0]       w_full_ext;
  logic [3:0]       w_empty_ext;
  logic             w_full;
  logic             w_dst_empty;
  logic             w_in_empty;
  logic             w_busy;
  logic             w_accept;
  logic             w_write;

  // Flags padded to four entries so a 2-bit address never indexes past the end.
  assign w_in_addr   = data_in[1:0];
  assign w_addr      = r_hdr[1:0];
  assign w_full_ext  = {1'b0, fifo_full};
  assign w_empty_ext = {1'b0, fifo_empty};
  assign w_full      = w_full_ext[w_addr];
  assign w_dst_empty = w_empty_ext[w_addr];
  assign w_in_empty  = w_empty_ext[w_in_addr];

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_WAIT_EMPTY, ST_LOAD_HDR:   w_busy = 1'b1;
      ST_LOAD_DATA, ST_LOAD_PARITY: w_busy = w_full;
      default:                      w_busy = 1'b0;
    endcase
  end

  assign w_accept = pkt_valid & ~w_busy;

  // Payload and parity pass straight through to the FIFO in the accepting cycle.
  always_comb begin
    w_write   = 1'b0;
    lfd_state = 1'b0;
    dout      = 8'd0;
    case (r_state)
      ST_LOAD_HDR: begin
        if (!w_full) begin
          w_write   = 1'b1;
          lfd_state = 1'b1;
          dout      = r_hdr;
        end
      end
      ST_LOAD_DATA, ST_LOAD_PARITY: begin
        if (w_accept) begin
          w_write = 1'b1;
          dout    = data_in;
        end
      end
      default: ;
    endcase
  end

  assign write_enb = w_write ? (NUM_PORTS'(1) << w_addr) : '0;
  assign busy      = w_busy;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_hdr       <= 8'd0;
      r_parity    <= 8'd0;
      r_remaining <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_hdr       <= data_in;
            r_parity    <= data_in;
            r_remaining <= hdr_len(data_in);
            if (w_in_addr == ADDR_INVALID) begin
              r_state <= ST_DROP;
            end else begin
              r_err   <= 1'b0;
              r_state <= w_in_empty ? ST_LOAD_HDR : ST_WAIT_EMPTY;
            end
          end
        end
        ST_WAIT_EMPTY: begin
          if (w_dst_empty) r_state <= ST_LOAD_HDR;
        end
        ST_LOAD_HDR: begin
          if (!w_full) r_state <= (r_remaining != '0) ? ST_LOAD_DATA : ST_LOAD_PARITY;
        end
        ST_LOAD_DATA: begin
          if (w_accept) begin
            r_parity    <= r_parity ^ data_in;
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) r_state <= ST_LOAD_PARITY;
          end
        end
        ST_LOAD_PARITY: begin
          if (w_accept) begin
            r_err   <= (data_in != r_parity);
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          // Dropped packets consume len payload bytes plus the parity byte.
          if (w_accept) begin
            if (r_remaining == '0) r_state <= ST_IDLE;
            else r_remaining <= r_remaining - LEN_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_router_ingress.sv
// ============================================================================
// Module      : tb_router_ingress
// Description : Self-checking bench for router_ingress against a packet-level
//               reference model (expected write stream, parity, busy phases).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_router_ingress;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic [7:0] dout;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic exp_err = 1'b0;
  logic [7:0] pkt_q[$];

  router_ingress dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .dout       (dout),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Build header, payload (sequential 1..len or random) and correct parity.
  task automatic make_pkt(input logic [7:0] hdr, input bit rnd_payload);
    logic [7:0] par;
    logic [7:0] b;
    pkt_q.delete();
    pkt_q.push_back(hdr);
    par = hdr;
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = rnd_payload ? 8'($urandom_range(0, 255)) : 8'(i + 1);
      pkt_q.push_back(b);
      par = par ^ b;
    end
    pkt_q.push_back(par);
  endtask

  // Drives pkt_q through the DUT and checks every cycle against the packet model.
  task automatic run_packet(input int gap_pct, input int full_pct, input int nempty_pct,
                            input int empty_hold, input int full_byte, input int full_cycles,
                            output int wait_busy, output int full_busy);
    logic [1:0] addr;
    bit         valid_dst;
    int         nbytes;
    int         idx = 0;
    int         wr_idx = 0;
    int         cyc = 0;
    int         empty_left;
    int         full_left;
    bit         hdr_acc = 0;
    bit         hdr_written = 0;
    bit         seen_empty = 0;
    bit         hdr_just = 0;
    bit         forced_e;
    bit         forced_f;
    bit         accepted;
    logic       exp_busy;
    logic       prior_err;
    logic [7:0] xsum = 8'd0;
    addr       = pkt_q[0][1:0];
    valid_dst  = (addr != 2'd3);
    nbytes     = pkt_q.size();
    empty_left = empty_hold;
    full_left  = full_cycles;
    prior_err  = exp_err;
    wait_busy  = 0;
    full_busy  = 0;
    foreach (pkt_q[i]) xsum = xsum ^ pkt_q[i];

    while (idx < nbytes && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      pkt_valid = ($urandom_range(0, 99) >= gap_pct);
      data_in   = pkt_q[idx];
      for (int p = 0; p < 3; p++) begin
        fifo_full[p]  = ($urandom_range(0, 99) < full_pct);
        fifo_empty[p] = ($urandom_range(0, 99) >= nempty_pct);
      end
      forced_e = 0;
      forced_f = 0;
      if (valid_dst && !hdr_written && empty_left > 0) begin
        fifo_empty[addr] = 1'b0;
        empty_left--;
        forced_e = hdr_acc;
      end
      if (valid_dst && hdr_written && idx == full_byte && full_left > 0) begin
        fifo_full[addr] = 1'b1;
        full_left--;
        forced_f = 1;
      end
      #1;
      if (forced_e && busy) wait_busy++;
      if (forced_f && busy) full_busy++;

      if (hdr_just) begin
        hdr_just = 0;
        checks++;
        if (err !== (valid_dst ? 1'b0 : prior_err))
          $display("FAIL err_after_header: got %b expected %b", err, valid_dst ? 1'b0 : prior_err);
        if (err !== (valid_dst ? 1'b0 : prior_err)) errors++;
      end

      if (!valid_dst || !hdr_acc) exp_busy = 1'b0;
      else if (!hdr_written) exp_busy = 1'b1;
      else exp_busy = fifo_full[addr];
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy: got %b expected %b (byte %0d)", busy, exp_busy, idx);
      end

      accepted = pkt_valid && !busy;
      if (write_enb !== 3'b000) begin
        checks++;
        if (!valid_dst || wr_idx >= nbytes) begin
          errors++;
          $display("FAIL unexpected_write: write_enb=%b dout=%h", write_enb, dout);
        end else if (write_enb !== (3'b001 << addr) || dout !== pkt_q[wr_idx] ||
                     lfd_state !== (wr_idx == 0) || fifo_full[addr] !== 1'b0 ||
                     (wr_idx == 0 && !seen_empty) || (wr_idx > 0 && (wr_idx != idx || !accepted))) begin
          errors++;
          $display("FAIL write_%0d: got en=%b dout=%h lfd=%b expected en=%b dout=%h lfd=%b (empty_seen=%b)",
                   wr_idx, write_enb, dout, lfd_state, 3'b001 << addr, pkt_q[wr_idx], wr_idx == 0, seen_empty);
        end
        wr_idx++;
        if (wr_idx == 1) hdr_written = 1;
      end else begin
        checks++;
        if (lfd_state !== 1'b0 || dout !== 8'd0 || (valid_dst && hdr_written && accepted)) begin
          errors++;
          $display("FAIL idle_outputs: got lfd=%b dout=%h (missing write at byte %0d: %b)",
                   lfd_state, dout, idx, valid_dst && hdr_written && accepted);
        end
      end

      if (valid_dst && (hdr_acc || (accepted && idx == 0)) && fifo_empty[addr]) seen_empty = 1;
      if (accepted) begin
        if (idx == 0) begin
          hdr_acc  = 1;
          hdr_just = 1;
        end
        idx++;
      end
    end

    if (cyc >= 3000) begin
      errors++;
      $display("FAIL packet_timeout: accepted %0d of %0d bytes", idx, nbytes);
    end
    @(negedge clk);
    pkt_valid  = 1'b0;
    fifo_full  = 3'b000;
    fifo_empty = 3'b111;
    #1;
    exp_err = valid_dst ? (xsum != 8'd0) : prior_err;
    checks++;
    if (err !== exp_err || wr_idx != (valid_dst ? nbytes : 0)) begin
      errors++;
      $display("FAIL packet_end: err=%b writes=%0d expected err=%b writes=%0d",
               err, wr_idx, exp_err, valid_dst ? nbytes : 0);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({write_enb, lfd_state, dout, busy, err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b lfd=%b dout=%h busy=%b err=%b expected all 0",
               write_enb, lfd_state, dout, busy, err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_good_packet();
    int wb, fb;
    make_pkt(8'h15, 0);
    checks++;
    if (pkt_q[6] !== 8'h14) begin
      errors++;
      $display("FAIL model_parity: got %h expected 14", pkt_q[6]);
    end
    run_packet(0, 0, 0, 0, -1, 0, wb, fb);
  endtask

  task automatic test_bad_parity();
    int wb, fb;
    make_pkt(8'h15, 0);
    pkt_q[pkt_q.size() - 1] = 8'h00;
    run_packet(0, 0, 0, 0, -1, 0, wb, fb);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL bad_parity_err: got %b expected 1", err);
    end
  endtask

  task automatic test_drop();
    int wb, fb;
    make_pkt(8'h0B, 1);
    run_packet(0, 0, 0, 0, -1, 0, wb, fb);
  endtask

  task automatic test_wait_empty();
    int wb, fb;
    make_pkt(8'h08, 1);
    run_packet(0, 0, 0, 5, -1, 0, wb, fb);
    checks++;
    if (wb != 4) begin
      errors++;
      $display("FAIL wait_empty_busy: got %0d busy cycles expected 4", wb);
    end
  endtask

  task automatic test_full_stall();
    int wb, fb;
    make_pkt(8'h0E, 1);
    run_packet(0, 0, 0, 0, 2, 3, wb, fb);
    checks++;
    if (fb != 3) begin
      errors++;
      $display("FAIL full_stall_busy: got %0d busy cycles expected 3", fb);
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    int guard = 0;
    int wb, fb;
    make_pkt(8'h15, 0);
    while (idx < 3 && guard < 50) begin
      @(negedge clk);
      pkt_valid  = 1'b1;
      data_in    = pkt_q[idx];
      fifo_full  = 3'b000;
      fifo_empty = 3'b111;
      #1;
      if (!busy) idx++;
      guard++;
    end
    if (guard >= 50) begin
      errors++;
      $display("FAIL reset_mid_timeout: accepted %0d of 3 bytes", idx);
    end
    @(negedge clk);
    data_in = 8'h03;
    rst     = 1'b0;
    #1;
    checks++;
    if ({write_enb, lfd_state, dout, busy, err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got en=%b lfd=%b dout=%h busy=%b err=%b expected all 0",
               write_enb, lfd_state, dout, busy, err);
    end
    @(negedge clk);
    pkt_valid = 1'b0;
    rst       = 1'b1;
    exp_err   = 1'b0;
    make_pkt(8'h05, 1);
    run_packet(0, 0, 0, 0, -1, 0, wb, fb);
  endtask

  task automatic test_random();
    int wb, fb;
    logic [7:0] hdr;
    for (int n = 0; n < 40; n++) begin
      hdr[1:0] = 2'($urandom_range(0, 3));
      hdr[7:2] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
      make_pkt(hdr, 1);
      if ($urandom_range(0, 2) == 0) pkt_q[pkt_q.size() - 1] ^= 8'($urandom_range(1, 255));
      run_packet(20, 25, 30, 0, -1, 0, wb, fb);
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_drop();
    test_wait_empty();
    test_full_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/router_ingress.md
ROUTER_INGRESS -- requirements
Module: router_ingress

Interface
REQ-001 Parameters: none; byte width 8 and port count 3 are fixed by the packet format.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 pkt_valid  in  1  source presents a packet byte on data_in.
REQ-006 data_in  in  8  packet byte: header, payload or parity.
REQ-007 fifo_full  in  3  per-destination FIFO full flags.
REQ-008 fifo_empty  in  3  per-destination FIFO empty flags.
REQ-009 write_enb  out  3  one-hot write strobe to the destination FIFO.
REQ-010 lfd_state  out  1  marks the header write, tagged as FIFO bit 8.
REQ-011 dout  out  8  byte to the FIFO din.
REQ-012 busy  out  1  source must hold the current byte while high.
REQ-013 err  out  1  parity mismatch on the last packet.

Function
REQ-014 Packet format SHALL be: header byte, then len payload bytes, then one parity byte.
- Header [1:0] = destination addr; addr 3 is invalid.
- Header [7:2] = len, 0..63.
- pkt_valid is high for every byte.
REQ-015 A byte SHALL be accepted only on a rising edge where pkt_valid=1 and busy=0.
REQ-016 FSM states SHALL be IDLE, WAIT_EMPTY, LOAD_HDR, LOAD_DATA, LOAD_PARITY, DROP.
REQ-017 IDLE, busy=0; on an accepted byte:
- capture header into hdr_reg; parity_acc = header; remaining = len.
- go to DROP if addr==3.
- else go to LOAD_HDR if fifo_empty[addr]=1.
- else go to WAIT_EMPTY.
REQ-018 WAIT_EMPTY, busy=1; go to LOAD_HDR the cycle after fifo_empty[addr]=1 is sampled.
REQ-019 LOAD_HDR, busy=1; if fifo_full[addr]=0:
- drive write_enb[addr]=1, lfd_state=1, dout=hdr_reg.
- go to LOAD_DATA if len>0, else LOAD_PARITY.
- else hold state with no write.
REQ-020 LOAD_DATA, busy=fifo_full[addr]; on an accepted byte:
- write_enb[addr]=1, dout=data_in (same cycle), parity_acc ^= data_in, remaining -= 1.
- go to LOAD_PARITY when remaining becomes 0.
REQ-021 LOAD_PARITY, busy=fifo_full[addr]; on an accepted byte:
- write it as in REQ-020.
- register err = (data_in != parity_acc).
- go to IDLE.
REQ-022 DROP, busy=0; consume len+1 bytes with write_enb=0, then go to IDLE; err is unchanged.
REQ-023 When no write occurs, write_enb=0, lfd_state=0 and dout=0.
REQ-024 If pkt_valid=0 mid-packet, state and counters SHALL hold; there is no timeout.
REQ-025 err SHALL hold its value until the next valid header is accepted, which clears it to 0.
REQ-026 At most one write_enb bit SHALL be high in any cycle, and never for addr 3.
REQ-027 The block SHALL write exactly len+2 bytes per valid packet; fifo_full SHALL never be high on a cycle with a write.

Reset
REQ-028 rst=0 SHALL immediately force state=IDLE, hdr_reg=0, parity_acc=0, remaining=0, err=0.
- Outputs: write_enb=0, lfd_state=0, dout=0, busy=0.
REQ-029 Reset mid-packet SHALL abandon the packet; after release, the next accepted byte is treated as a header.

Structure
REQ-030 Shared package router_pkg SHALL hold:
- the FSM state enum;
- ADDR_INVALID=2'd3, NUM_PORTS=3, LEN_W=6.
REQ-031 The block SHALL be one module with no sub-module; the parity accumulator and counter are inline.

Verification
REQ-032 Header 0x15 (addr 1, len 5), payload 01..05, parity 0x14, FIFO1 empty:
- 7 writes on write_enb=3'b010; lfd_state=1 only on the 0x15 write; err=0.
REQ-033 Same packet with parity byte 0x00 -> 7 writes, then err=1; err clears when the next valid header is accepted.
REQ-034 Header 0x08 (addr 0, len 2) with fifo_empty[0]=0 for 4 cycles:
- busy=1 throughout; no write until fifo_empty[0]=1.
- then the header is written with lfd_state=1.
REQ-035 fifo_full[2]=1 for 3 cycles during payload 2 of header 0x0E (addr 2, len 3):
- busy=1 for those cycles; payload 2 is written once, after full drops; no byte is lost or duplicated.
REQ-036 Header 0x0B (addr 3, len 2) -> 4 bytes consumed, write_enb=0 throughout, err unchanged, then back to IDLE.
REQ-037 rst=0 after payload 2 of a len-5 packet:
- outputs are 0 immediately.
- after release, the next byte 0x05 is taken as a header (addr 1, len 1).
